// File: rtl/tape_line_filter.sv
// Cassette line conditioner: pin synchroniser, glitch filter, half-period
// measurement, motor gating and activity detection for the tape input.
module tape_line_filter #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 4,
  parameter logic [15:0] MIN_PER     = 16'd40,
  parameter logic [15:0] MAX_PER     = 16'd1200,
  parameter logic [15:0] ACT_TIMEOUT = 16'd16000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        tape_raw,
  input  logic        motor_on,
  output logic        tape_bit,
  output logic        edge_strobe,
  output logic [15:0] period,
  output logic        period_valid,
  output logic        activity
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [FILT_LEN-1:0]    hist_r;
  logic                   state_r;
  logic [15:0]            cnt_r;
  logic                   seen_r;

  logic                   sample_s;
  logic                   agree_s;
  logic                   accept_s;
  logic [15:0]            cnt_inc_s;
  logic                   in_range_s;

  // Pin synchroniser, free-running on every system clock
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], tape_raw};
    end
  end

  // An edge is accepted when the incoming sample completes a full run of
  // FILT_LEN equal samples that differs from the current filtered level.
  always_comb begin
    sample_s   = sync_r[SYNC_STAGES-1];
    agree_s    = (hist_r[FILT_LEN-2:0] == {(FILT_LEN-1){sample_s}});
    accept_s   = ce && agree_s && (sample_s != state_r);
    cnt_inc_s  = (cnt_r == 16'hFFFF) ? 16'hFFFF : (cnt_r + 16'd1);
    in_range_s = (cnt_inc_s >= MIN_PER) && (cnt_inc_s <= MAX_PER);
  end

  // Sample history and filtered level; keeps tracking even with the motor off
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hist_r  <= '0;
      state_r <= 1'b0;
    end else if (ce) begin
      hist_r <= {hist_r[FILT_LEN-2:0], sample_s};
      if (accept_s) begin
        state_r <= sample_s;
      end
    end
  end

  // Half-period measurement, strobes and activity; motor off holds a clean restart point
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_r        <= 16'd0;
      seen_r       <= 1'b0;
      period       <= 16'd0;
      period_valid <= 1'b0;
      edge_strobe  <= 1'b0;
      activity     <= 1'b0;
    end else begin
      edge_strobe  <= 1'b0;
      period_valid <= 1'b0;
      if (!motor_on) begin
        cnt_r    <= 16'd0;
        seen_r   <= 1'b0;
        activity <= 1'b0;
      end else if (accept_s) begin
        // An edge takes priority over a timeout landing on the same tick
        cnt_r       <= 16'd0;
        seen_r      <= 1'b1;
        edge_strobe <= 1'b1;
        if (seen_r) begin
          period       <= cnt_inc_s;
          period_valid <= 1'b1;
          if (in_range_s) begin
            activity <= 1'b1;
          end
        end
      end else if (ce) begin
        cnt_r <= cnt_inc_s;
        if (cnt_inc_s >= ACT_TIMEOUT) begin
          activity <= 1'b0;
        end
      end
    end
  end

  assign tape_bit = state_r & motor_on;

endmodule
